bcd_countdown: RTL and testbench
================================

BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 The block SHALL have parameter DIGITS, default 6, giving the number of BCD digits.
REQ-002 The block SHALL have parameter MAX, default 9, giving the top value of each digit (wrap-to value on borrow).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port ce, input, 1 bit, count enable; one decrement per clk edge with ce=1 in RUN.
REQ-006 The block SHALL have port clr, input, 1 bit, synchronous clear to IDLE.
REQ-007 The block SHALL have port load, input, 1 bit, synchronous load strobe.
REQ-008 The block SHALL have port load_val, input, DIGITS*4 bits, packed BCD start value, digit 0 in bits [3:0].
REQ-009 The block SHALL have port cnt, output, DIGITS*4 bits, registered packed BCD count.
REQ-010 The block SHALL have port busy, output, 1 bit, high while state is RUN.
REQ-011 The block SHALL have port zero, output, 1 bit, high when cnt equals all-zero digits.
REQ-012 The block SHALL have port tc, output, 1 bit, registered one-cycle terminal-count pulse.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 Priority each edge SHALL be clr > load > ce; lower-priority inputs are ignored that cycle.
REQ-015 clr SHALL set cnt=0, tc=0, state=IDLE on the next edge, from any state.
REQ-016 load SHALL capture load_val into cnt on the next edge, from any state; no decrement occurs that cycle.
REQ-017 Each loaded digit >MAX SHALL be clamped to MAX.
REQ-018 load of a non-zero value (after clamping) SHALL enter RUN; load of all-zero SHALL enter DONE without a tc pulse.
REQ-019 In RUN with ce=1, digit 0 SHALL decrement; digit i>0 SHALL decrement only when all lower digits are 0; a decrementing digit at 0 SHALL become MAX.
REQ-020 The full borrow chain SHALL resolve within one cycle: cnt reflects the new value on the edge after ce (latency 1).
REQ-021 When a RUN decrement makes cnt all-zero, the block SHALL enter DONE and assert tc for exactly that following cycle.
REQ-022 ce SHALL be ignored in IDLE and DONE; cnt SHALL never wrap below zero.
REQ-023 DONE SHALL hold cnt=0 until load or clr.
REQ-024 busy SHALL be 1 exactly when state is RUN; zero SHALL be a combinational decode of cnt.
REQ-025 tc SHALL be 0 in every cycle not covered by REQ-021, including the cycle after load or clr.

Reset
REQ-026 rst_n low SHALL immediately and asynchronously force cnt=0, tc=0, state=IDLE, so busy=0 and zero=1.
REQ-027 Reset asserted mid-RUN SHALL abort the count with no tc pulse; operation SHALL resume only by load after rst_n is released.

Structure
REQ-028 A shared package SHALL hold the FSM state type (IDLE/RUN/DONE) and the constant BCD_W=4.
REQ-029 One sub-module, bcd_digit_dec, SHALL implement a single digit: inputs digit and borrow_in; outputs next digit and borrow_out (borrow_in and digit==0).
REQ-030 The top SHALL instantiate DIGITS copies of bcd_digit_dec in a chain; borrow_in of digit 0 SHALL be ce while in RUN.

Verification
REQ-031 The bench SHALL load 000105 and then apply 105 ce pulses: tc SHALL pulse once, one cycle after the 105th ce; then cnt=000000, busy=0, zero=1.
REQ-032 The bench SHALL load 100000 and apply one ce: cnt SHALL become 099999 in one cycle (full borrow chain).
REQ-033 The bench SHALL load 000000: the FSM SHALL enter DONE, and tc SHALL stay 0; further ce pulses SHALL leave cnt=000000.
REQ-034 The bench SHALL load digits A,F,3,0,C,1 (hex, digit 5 down to 0): cnt SHALL become 9,9,3,0,9,1.
REQ-035 The bench SHALL assert clr, load and ce in the same cycle during RUN: the result SHALL be IDLE with cnt=0; load with ce SHALL load without a decrement.
REQ-036 The bench SHALL drop rst_n mid-RUN between clock edges: cnt=0 and busy=0 SHALL take effect immediately, with no tc pulse afterward.

Source files
------------

// File: rtl/bcd_countdown_pkg.sv
// Shared types and constants for the BCD down-counter: FSM state encoding,
// digit width and the load-time digit clamp.
package bcd_countdown_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d,
                                                   input logic [BCD_W-1:0] max_d);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the down-counter: decrements on borrow_in, wraps 0 -> MAX
// and passes the borrow upward when it wraps.
module bcd_digit_dec
  import bcd_countdown_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic [BCD_W-1:0] digit,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit_next,
  output logic             borrow_out
);

  localparam logic [BCD_W-1:0] MAX_D = BCD_W'(MAX);

  always_comb begin
    digit_next = digit;
    if (borrow_in) begin
      digit_next = (digit == '0) ? MAX_D : digit - BCD_W'(1);
    end
  end

  assign borrow_out = borrow_in && (digit == '0);

endmodule

// File: rtl/bcd_countdown.sv
// Multi-digit BCD down-counter with load/clear, run/done sequencing and a
// registered terminal-count pulse when a running count reaches zero.
//
//   state | meaning
//   IDLE  | after reset or clr; ce ignored, waiting for load
//   RUN   | counting down one step per ce
//   DONE  | count reached (or loaded as) zero; ce ignored until load/clr
module bcd_countdown
  import bcd_countdown_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int MAX    = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic                    clr,
  input  logic                    load,
  input  logic [DIGITS*BCD_W-1:0] load_val,
  output logic [DIGITS*BCD_W-1:0] cnt,
  output logic                    busy,
  output logic                    zero,
  output logic                    tc
);

  localparam int               CW    = DIGITS * BCD_W;
  localparam logic [BCD_W-1:0] MAX_D = BCD_W'(MAX);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tc_q, tc_d;
  logic [CW-1:0]   cnt_dec;
  logic [CW-1:0]   load_clamped;
  logic [DIGITS:0] borrow;

  assign borrow[0] = ce && (state_q == ST_RUN);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_dec #(.MAX(MAX)) u_digit (
      .digit      (cnt_q[g*BCD_W +: BCD_W]),
      .borrow_in  (borrow[g]),
      .digit_next (cnt_dec[g*BCD_W +: BCD_W]),
      .borrow_out (borrow[g+1])
    );
  end

  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[i*BCD_W +: BCD_W] = clamp_digit(load_val[i*BCD_W +: BCD_W], MAX_D);
    end
  end

  // A borrow out of the top digit would mean decrementing past zero; hold instead.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (load) begin
      cnt_d   = load_clamped;
      state_d = (load_clamped == '0) ? ST_DONE : ST_RUN;
    end else if (state_q == ST_RUN && ce && !borrow[DIGITS]) begin
      cnt_d = cnt_dec;
      if (cnt_dec == '0) begin
        state_d = ST_DONE;
        tc_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
    end
  end

  assign cnt  = cnt_q;
  assign tc   = tc_q;
  assign busy = (state_q == ST_RUN);
  assign zero = (cnt_q == '0);

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed and randomized checks of bcd_countdown against an integer-valued
// reference model of the counter.
module tb_bcd_countdown;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [23:0] load_val = '0;
  logic [23:0] cnt;
  logic        busy, zero, tc;

  int checks = 0;
  int errors = 0;

  // Reference model: plain decimal value plus a mode (0 idle, 1 run, 2 done).
  int m_val  = 0;
  int m_mode = 0;
  bit m_tc   = 1'b0;

  bcd_countdown #(.DIGITS(6), .MAX(9)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .busy     (busy),
    .zero     (zero),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r = '0;
    int t = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int clamped_value(input logic [23:0] lv);
    int v = 0;
    int w = 1;
    int d;
    for (int i = 0; i < 6; i++) begin
      d = int'(lv[i*4 +: 4]);
      if (d > 9) d = 9;
      v += d * w;
      w *= 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_val = 0; m_mode = 0; m_tc = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic l, input logic [23:0] v, input logic e);
    m_tc = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (c) begin
      m_val = 0; m_mode = 0;
    end else if (l) begin
      m_val  = clamped_value(v);
      m_mode = (m_val != 0) ? 1 : 2;
    end else if (m_mode == 1 && e) begin
      m_val = m_val - 1;
      if (m_val == 0) begin
        m_mode = 2;
        m_tc   = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_cnt"},  32'(cnt),  32'(to_bcd(m_val)));
    check({tag, "_busy"}, 32'(busy), 32'(m_mode == 1));
    check({tag, "_zero"}, 32'(zero), 32'(m_val == 0));
    check({tag, "_tc"},   32'(tc),   32'(m_tc));
  endtask

  task automatic cycle(input string tag, input logic c, input logic l,
                       input logic [23:0] v, input logic e);
    clr = c; load = l; load_val = v; ce = e;
    @(posedge clk);
    #1;
    model_step(c, l, v, e);
    check_all(tag);
  endtask

  int tc_count;
  logic [31:0] rnd;
  logic [23:0] lv;

  initial begin
    // Reset state before any clock edge
    #2;
    model_reset();
    check_all("reset");
    #10 rst_n = 1'b1;
    cycle("idle_ce", 1'b0, 1'b0, '0, 1'b1);

    // Load 105 and count down to zero; tc must pulse exactly once
    cycle("load105", 1'b0, 1'b1, 24'h000105, 1'b0);
    tc_count = 0;
    for (int i = 0; i < 105; i++) begin
      cycle("cd105", 1'b0, 1'b0, '0, 1'b1);
      if (tc) tc_count++;
    end
    check("cd105_tc_at_end", 32'(tc), 32'd1);
    cycle("cd105_after", 1'b0, 1'b0, '0, 1'b1);
    cycle("cd105_after2", 1'b0, 1'b0, '0, 1'b0);
    check("cd105_tc_count", 32'(tc_count), 32'd1);

    // Full borrow chain in one cycle
    cycle("load100000", 1'b0, 1'b1, 24'h100000, 1'b0);
    cycle("borrow_chain", 1'b0, 1'b0, '0, 1'b1);
    check("borrow_099999", 32'(cnt), 32'h00099999);

    // Load zero: DONE without tc, ce ignored
    cycle("load_zero", 1'b0, 1'b1, 24'h000000, 1'b1);
    for (int i = 0; i < 3; i++) cycle("zero_ce", 1'b0, 1'b0, '0, 1'b1);

    // Clamping of out-of-range digits
    cycle("clamp", 1'b0, 1'b1, 24'hAF30C1, 1'b0);
    check("clamp_993091", 32'(cnt), 32'h00993091);
    cycle("clamp_dec", 1'b0, 1'b0, '0, 1'b1);

    // clr beats load beats ce; load with ce loads without decrement
    cycle("prio_all", 1'b1, 1'b1, 24'h000777, 1'b1);
    cycle("prio_idle", 1'b0, 1'b0, '0, 1'b1);
    cycle("load_run", 1'b0, 1'b1, 24'h000020, 1'b0);
    cycle("run_dec", 1'b0, 1'b0, '0, 1'b1);
    cycle("load_ce", 1'b0, 1'b1, 24'h000042, 1'b1);
    check("load_ce_nodec", 32'(cnt), 32'h00000042);

    // Asynchronous reset mid-RUN, between edges
    cycle("pre_rst", 1'b0, 1'b0, '0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    for (int i = 0; i < 2; i++) cycle("in_rst", 1'b0, 1'b0, '0, 1'b1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle("post_rst", 1'b0, 1'b0, '0, 1'b1);
    cycle("resume", 1'b0, 1'b1, 24'h000003, 1'b0);
    for (int i = 0; i < 4; i++) cycle("resume_cd", 1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rnd = $urandom();
      lv  = 24'($urandom());
      if (rnd[31]) lv = {16'h0000, lv[7:0]};
      cycle("rand", rnd[6:0] < 7'd2, rnd[14:8] < 7'd6, lv, rnd[17:16] != 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
